// File: rtl/backprop_sequencer.sv
// backprop_sequencer
//   Walks one dense layer for a backprop pass. For every previous-layer input
//   i (outer loop) and every layer output j (inner loop) it reads the previous
//   activation, the backprop value and the weight j*N_IN+i. It feeds these to
//   a shared combinational datapath and writes the updated weight back. It also
//   sums the datapath's change terms over j and emits that sum as the
//   propagated error for input i.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request one pass (only honoured in IDLE)
//   busy, done            pass in progress / 1-cycle completion pulse
//   prev_addr, prev_data  previous-activation buffer, 1-cycle read latency
//   bp_addr, bp_data      backprop-value buffer, 1-cycle read latency
//   w_raddr, w_rdata      weight memory read port, 1-cycle read latency
//   w_we, w_waddr, w_wdata  weight memory write port
//   dp_previous, dp_weight, dp_backprop  operands to the shared datapath
//   dp_change, dp_weight_new             results from the shared datapath
//   err_valid, err_addr, err_data, err_ready  propagated-error stream
//   fsm_state             current FSM state (debug visibility)
//
// Handshake: an err transfer happens on a rising edge where err_valid and
// err_ready are both 1. Once err_valid rises, err_addr/err_data hold stable
// until that transfer.
//
// Configuration
//   BP_SEQ_SATURATE_EN  defined: the error accumulator saturates on signed
//                       overflow. Undefined: it wraps modulo 2^32.
module backprop_sequencer #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  localparam int AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int BW  = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int WAW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  prev_addr,
  input  logic [31:0]    prev_data,
  output logic [BW-1:0]  bp_addr,
  input  logic [31:0]    bp_data,
  output logic [WAW-1:0] w_raddr,
  input  logic [31:0]    w_rdata,
  output logic           w_we,
  output logic [WAW-1:0] w_waddr,
  output logic [31:0]    w_wdata,
  output logic [31:0]    dp_previous,
  output logic [31:0]    dp_weight,
  output logic [31:0]    dp_backprop,
  input  logic [31:0]    dp_change,
  input  logic [31:0]    dp_weight_new,
  output logic           err_valid,
  output logic [AW-1:0]  err_addr,
  output logic [31:0]    err_data,
  input  logic           err_ready,
  output logic [2:0]     fsm_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state, state_next;
  logic [AW-1:0]  i;
  logic [BW-1:0]  j;
  logic [31:0]    acc;
  logic [31:0]    acc_sum;
  logic [31:0]    sum_raw;
  logic [WAW-1:0] w_addr;
  logic           last_i, last_j;

  assign last_i = (i == AW'(N_IN - 1));
  assign last_j = (j == BW'(N_OUT - 1));

  // Weights are stored output-major: row j holds the N_IN weights of output j.
  assign w_addr = WAW'(int'(j) * N_IN + int'(i));

  assign sum_raw = acc + dp_change;

`ifdef BP_SEQ_SATURATE_EN
  logic overflow;
  // Signed overflow: both operands share a sign and the result's sign differs.
  assign overflow = (acc[31] == dp_change[31]) && (sum_raw[31] != acc[31]);
  assign acc_sum  = overflow ? (acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum_raw;
`else
  assign acc_sum = sum_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            i   <= '0;
            j   <= '0;
            acc <= '0;
          end
        end
        EXEC: begin
          acc <= acc_sum;
          if (!last_j) j <= j + BW'(1);
        end
        EMIT: begin
          // Starting the next input restarts j, so the error sum restarts too.
          if (err_ready && !last_i) begin
            i   <= i + AW'(1);
            j   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done        = 1'b0;
    w_we        = 1'b0;
    err_valid   = 1'b0;
    dp_previous = '0;
    dp_weight   = '0;
    dp_backprop = '0;
    case (state)
      IDLE: begin
        if (start) state_next = READ;
      end
      READ: begin
        busy       = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        busy        = 1'b1;
        w_we        = 1'b1;
        dp_previous = prev_data;
        dp_weight   = w_rdata;
        dp_backprop = bp_data;
        state_next  = last_j ? EMIT : READ;
      end
      EMIT: begin
        busy      = 1'b1;
        err_valid = 1'b1;
        if (err_ready) state_next = last_i ? DONE : READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read addresses are driven continuously from the indices. They are set up
  // in READ, and the memories return data during the following EXEC.
  assign prev_addr = i;
  assign bp_addr   = j;
  assign w_raddr   = w_addr;
  assign w_waddr   = w_addr;
  assign w_wdata   = dp_weight_new;
  assign err_addr  = i;
  assign err_data  = acc;
  assign fsm_state = state;

endmodule

// File: tb/tb_backprop_sequencer.sv
module tb_backprop_sequencer;
  localparam int N_IN     = 2;
  localparam int N_OUT    = 2;
  localparam int N_W      = N_IN * N_OUT;
  localparam int AW       = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int BW       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int WAW      = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int EW       = AW + 32;
  localparam int PASS_CYC = N_IN * (2 * N_OUT + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n, start, err_ready;
  always #5 clk = ~clk;

  logic           busy, done, w_we, err_valid;
  logic [AW-1:0]  prev_addr, err_addr;
  logic [BW-1:0]  bp_addr;
  logic [WAW-1:0] w_raddr, w_waddr;
  logic [31:0]    prev_data, bp_data, w_rdata, w_wdata, err_data;
  logic [31:0]    dp_previous, dp_weight, dp_backprop, dp_change, dp_weight_new;
  logic [2:0]     fsm_state;

  backprop_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .prev_addr(prev_addr), .prev_data(prev_data),
    .bp_addr(bp_addr), .bp_data(bp_data),
    .w_raddr(w_raddr), .w_rdata(w_rdata),
    .w_we(w_we), .w_waddr(w_waddr), .w_wdata(w_wdata),
    .dp_previous(dp_previous), .dp_weight(dp_weight), .dp_backprop(dp_backprop),
    .dp_change(dp_change), .dp_weight_new(dp_weight_new),
    .err_valid(err_valid), .err_addr(err_addr), .err_data(err_data),
    .err_ready(err_ready), .fsm_state(fsm_state)
  );

  // ---------------- environment: datapath and memories ----------------
  logic        use_const;
  logic [31:0] change_const;
  logic [31:0] prev_mem[N_IN];
  logic [31:0] bp_mem[N_OUT];
  logic [31:0] w_mem[N_W];
  logic [31:0] w_seed[N_W];
  logic        w_load;

  assign dp_change     = use_const ? change_const : (dp_weight * dp_backprop + dp_previous);
  assign dp_weight_new = dp_weight - (dp_previous ^ dp_backprop);

  logic [WAW-1:0] obs_waddr_q[$];
  logic [EW-1:0]  obs_err_q[$];

  always @(posedge clk) begin
    prev_data <= prev_mem[prev_addr];
    bp_data   <= bp_mem[bp_addr];
    w_rdata   <= w_mem[w_raddr];
    if (w_load) w_mem <= w_seed;
    else if (w_we) begin
      w_mem[w_waddr] <= w_wdata;
      obs_waddr_q.push_back(w_waddr);
    end
    if (err_valid && err_ready) obs_err_q.push_back({err_addr, err_data});
  end

  int cyc, busy_cnt, done_cnt, last_busy_cyc, done_cyc;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (busy) begin
      busy_cnt      <= busy_cnt + 1;
      last_busy_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0]  exp_q[$];
  logic [WAW-1:0] exp_waddr_q[$];
  logic [31:0]    exp_w[N_W];
  int total, bad;

  function automatic logic [31:0] ref_add(logic [31:0] a, logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef BP_SEQ_SATURATE_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  // Whole-pass model: every input i sees every output j in order, every weight
  // is updated once, and error i is the sum of change terms over j.
  task automatic build_expected();
    logic [31:0] wm[N_W];
    logic [31:0] a, ch;
    int adr;
    exp_q.delete();
    exp_waddr_q.delete();
    for (int k = 0; k < N_W; k++) wm[k] = w_mem[k];
    for (int ii = 0; ii < N_IN; ii++) begin
      a = '0;
      for (int jj = 0; jj < N_OUT; jj++) begin
        adr = jj * N_IN + ii;
        ch = use_const ? change_const : (wm[adr] * bp_mem[jj] + prev_mem[ii]);
        wm[adr] = wm[adr] - (prev_mem[ii] ^ bp_mem[jj]);
        a = ref_add(a, ch);
        exp_waddr_q.push_back(WAW'(adr));
      end
      exp_q.push_back({AW'(ii), a});
    end
    for (int k = 0; k < N_W; k++) exp_w[k] = wm[k];
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_random();
    for (int k = 0; k < N_IN; k++) prev_mem[k] = $urandom;
    for (int k = 0; k < N_OUT; k++) bp_mem[k] = $urandom;
    for (int k = 0; k < N_W; k++) w_seed[k] = $urandom;
    @(posedge clk); #1 w_load = 1'b1;
    @(posedge clk); #1 w_load = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; err_ready = 1'b1;
    use_const = 1'b0; change_const = '0; w_load = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (w_we !== 1'b0) begin bad++; $display("FAIL reset_w_we: got %b want 0", w_we); end
    total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL reset_err_valid: got %b want 0", err_valid); end
    @(posedge clk); #1 rst_n = 1'b1;
    load_random();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_random_passes();
    int wb, eb, b0, d0;
    bit ok;
    for (int p = 0; p < 3; p++) begin
      if (p > 0) load_random();
      build_expected();
      wb = obs_waddr_q.size(); eb = obs_err_q.size(); b0 = busy_cnt; d0 = done_cnt;
      pulse_start();
      wait_done(60, ok);
      total++; if (!ok) begin bad++; $display("FAIL pass%0d_timeout: no done within 60 cycles", p); end
      total++;
      if (busy_cnt - b0 != PASS_CYC) begin
        bad++; $display("FAIL pass%0d_busy_cycles: got %0d want %0d", p, busy_cnt - b0, PASS_CYC);
      end
      total++;
      if (done_cyc != last_busy_cyc + 1) begin
        bad++; $display("FAIL pass%0d_done_follows_busy: done at %0d last busy %0d", p, done_cyc, last_busy_cyc);
      end
      @(negedge clk); #1;
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL pass%0d_done_pulses: got %0d want 1", p, done_cnt - d0); end
      total++;
      if (obs_waddr_q.size() - wb != N_W) begin
        bad++; $display("FAIL pass%0d_write_count: got %0d want %0d", p, obs_waddr_q.size() - wb, N_W);
      end else begin
        for (int k = 0; k < N_W; k++) begin
          total++;
          if (obs_waddr_q[wb + k] !== exp_waddr_q[k]) begin
            bad++; $display("FAIL pass%0d_write_order[%0d]: got %0d want %0d", p, k, obs_waddr_q[wb + k], exp_waddr_q[k]);
          end
        end
      end
      total++;
      if (obs_err_q.size() - eb != N_IN) begin
        bad++; $display("FAIL pass%0d_err_count: got %0d want %0d", p, obs_err_q.size() - eb, N_IN);
      end else begin
        for (int k = 0; k < N_IN; k++) begin
          total++;
          if (obs_err_q[eb + k] !== exp_q[k]) begin
            bad++; $display("FAIL pass%0d_err[%0d]: got %h want %h", p, k, obs_err_q[eb + k], exp_q[k]);
          end
        end
      end
      for (int k = 0; k < N_W; k++) begin
        total++;
        if (w_mem[k] !== exp_w[k]) begin
          bad++; $display("FAIL pass%0d_weight[%0d]: got %h want %h", p, k, w_mem[k], exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_const_change(input logic [31:0] c, input logic [31:0] want_data);
    int eb;
    bit ok;
    use_const = 1'b1; change_const = c;
    build_expected();
    eb = obs_err_q.size();
    pulse_start();
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL const_%h_timeout: no done", c); end
    total++;
    if (obs_err_q.size() - eb != N_IN) begin
      bad++; $display("FAIL const_%h_err_count: got %0d want %0d", c, obs_err_q.size() - eb, N_IN);
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        total++;
        if (obs_err_q[eb + k] !== {AW'(k), want_data}) begin
          bad++; $display("FAIL const_%h_err[%0d]: got %h want %h", c, k, obs_err_q[eb + k], {AW'(k), want_data});
        end
        total++;
        if (obs_err_q[eb + k] !== exp_q[k]) begin
          bad++; $display("FAIL const_%h_err_model[%0d]: got %h want %h", c, k, obs_err_q[eb + k], exp_q[k]);
        end
      end
    end
    use_const = 1'b0;
  endtask

  task automatic test_emit_stall();
    int eb, wb;
    bit ok, seen;
    logic [AW-1:0] a0;
    logic [31:0] d0;
    load_random();
    build_expected();
    eb = obs_err_q.size(); wb = obs_waddr_q.size();
    err_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (err_valid) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL stall_no_emit: err_valid never rose"); end
    a0 = err_addr; d0 = err_data;
    total++;
    if ({a0, d0} !== exp_q[0]) begin bad++; $display("FAIL stall_first_err: got %h want %h", {a0, d0}, exp_q[0]); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) err_ready = 1'b1;
      @(negedge clk);
      total++;
      if (err_valid !== 1'b1 || err_addr !== a0 || err_data !== d0) begin
        bad++; $display("FAIL stall_stable[%0d]: got v=%b a=%0d d=%h want v=1 a=%0d d=%h", k, err_valid, err_addr, err_data, a0, d0);
      end
      total++; if (w_we !== 1'b0) begin bad++; $display("FAIL stall_w_we[%0d]: got %b want 0", k, w_we); end
    end
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: no done after release"); end
    total++;
    if (obs_waddr_q.size() - wb != N_W) begin
      bad++; $display("FAIL stall_write_count: got %0d want %0d", obs_waddr_q.size() - wb, N_W);
    end
    total++;
    if (obs_err_q.size() - eb != N_IN || obs_err_q[obs_err_q.size() - 1] !== exp_q[N_IN - 1]) begin
      bad++; $display("FAIL stall_err_stream: got count %0d last %h want count %0d last %h",
                      obs_err_q.size() - eb, obs_err_q[obs_err_q.size() - 1], N_IN, exp_q[N_IN - 1]);
    end
  endtask

  task automatic test_start_while_busy();
    int wb, d0;
    bit ok;
    load_random();
    wb = obs_waddr_q.size(); d0 = done_cnt;
    pulse_start();
    repeat ($urandom_range(1, 6)) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL restart_timeout: no done"); end
    repeat (15) @(negedge clk);
    #1;
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL restart_done_pulses: got %0d want 1", done_cnt - d0); end
    total++;
    if (obs_waddr_q.size() - wb != N_W) begin
      bad++; $display("FAIL restart_write_count: got %0d want %0d", obs_waddr_q.size() - wb, N_W);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_pass();
    int wb, eb;
    bit ok, seen;
    logic [31:0] orig1;
    load_random();
    build_expected();
    orig1 = w_mem[1];
    wb = obs_waddr_q.size(); eb = obs_err_q.size();
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (w_we && w_waddr == WAW'(1)) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL midrst_no_exec1: EXEC of address 1 never seen"); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || w_we !== 1'b0 || err_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midrst_async_clear: got busy=%b w_we=%b err_valid=%b done=%b want all 0", busy, w_we, err_valid, done);
    end
    repeat (2) @(posedge clk);
    #1;
    total++; if (obs_waddr_q.size() - wb != 2) begin bad++; $display("FAIL midrst_writes: got %0d want 2", obs_waddr_q.size() - wb); end
    total++; if (obs_err_q.size() - eb != 1) begin bad++; $display("FAIL midrst_errs: got %0d want 1", obs_err_q.size() - eb); end
    total++; if (w_mem[1] !== orig1) begin bad++; $display("FAIL midrst_w1_untouched: got %h want %h", w_mem[1], orig1); end
    total++; if (w_mem[2] !== exp_w[2]) begin bad++; $display("FAIL midrst_w2_kept: got %h want %h", w_mem[2], exp_w[2]); end
    rst_n = 1'b1;
    build_expected();
    wb = obs_waddr_q.size(); eb = obs_err_q.size();
    pulse_start();
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_rerun_timeout: no done"); end
    total++;
    if (obs_waddr_q.size() - wb != N_W) begin
      bad++; $display("FAIL midrst_rerun_writes: got %0d want %0d", obs_waddr_q.size() - wb, N_W);
    end
    for (int k = 0; k < N_W; k++) begin
      total++;
      if (w_mem[k] !== exp_w[k]) begin bad++; $display("FAIL midrst_rerun_weight[%0d]: got %h want %h", k, w_mem[k], exp_w[k]); end
    end
    total++;
    if (obs_err_q.size() - eb != N_IN || obs_err_q[eb] !== exp_q[0]) begin
      bad++; $display("FAIL midrst_rerun_err0: got count %0d first %h want count %0d first %h",
                      obs_err_q.size() - eb, obs_err_q[eb], N_IN, exp_q[0]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    logic [31:0] sat_want;
`ifdef BP_SEQ_SATURATE_EN
    sat_want = 32'h7FFF_FFFF;
`else
    sat_want = 32'hFFFF_FFFE;
`endif
    test_reset();
    test_random_passes();
    test_const_change(32'd5, 32'd10);
    test_const_change(32'h7FFF_FFFF, sat_want);
    test_emit_stall();
    test_start_while_busy();
    test_reset_mid_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
